dmem_port_arbiter: RTL and testbench
====================================

Name: dmem_port_arbiter

Overview:
Shares the single-port synchronous data memory between the 5-stage pipeline CPU's data port and a debug readout port. The readout port is used by the board display logic (SW/button) to show memory contents on the 7-segment display while the CPU runs. The CPU has priority. A bounded-wait counter guarantees the debug port a slot by stalling the CPU for exactly one cycle. Sits between pcpu, d_mem and the display controller inside CPU.

Parameters:
AW, 8, memory address width
DW, 16, memory data width
MAX_WAIT, 15, maximum number of PEND cycles the debug port loses to the CPU before being forced in; 0 means the debug port always wins immediately

Ports:
clk  in  1  system clock, all state updates on rising edge
reset  in  1  synchronous, active-high reset
cpu_req  in  1  CPU performs a load/store this cycle
cpu_we  in  1  CPU store enable
cpu_addr  in  AW  CPU data address
cpu_wdata  in  DW  CPU store data
cpu_rdata  out  DW  load data; combinational pass-through of mem_rdata
cpu_stall  out  1  CPU must hold its MEM stage this cycle; combinational
dbg_req  in  1  debug read request; level, held until dbg_ack
dbg_addr  in  AW  debug read address; stable while dbg_req is high
dbg_ack  out  1  one-cycle pulse; dbg_rdata is valid in that cycle
dbg_rdata  out  DW  registered debug read data
mem_addr  out  AW  to d_mem
mem_we  out  1  to d_mem
mem_wdata  out  DW  to d_mem
mem_rdata  in  DW  from d_mem; valid the cycle after its address is presented

Behaviour:
- States: IDLE, PEND, CAPT, ACK, HOLD.
- Reset values: state=IDLE, wait_cnt=0, dbg_ack=0, dbg_rdata=0.
- IDLE: if dbg_req=1, next state is PEND.
- PEND decides the grant:
  - debug wins (dbg_grant=1) if cpu_req=0 or wait_cnt==MAX_WAIT; otherwise the CPU wins and wait_cnt increments.
  - If dbg_req=0 in PEND, abort: next state IDLE, no memory access, no ack, wait_cnt cleared.
  - When dbg_grant=1, next state is CAPT and wait_cnt is cleared.
- CAPT: dbg_rdata <= mem_rdata at the end of the cycle. The memory port is free for the CPU in this cycle. Next state is ACK.
- ACK: dbg_ack=1 for exactly this cycle. Next state is HOLD if dbg_req=1, else IDLE.
- HOLD: stays in HOLD until dbg_req=0, then goes to IDLE. Holding the request high never starts a second transaction; the request must be low for at least one cycle between transactions.
- Memory mux:
  - When dbg_grant=1: mem_addr=dbg_addr, mem_we=0, mem_wdata=0.
  - Otherwise: mem_addr=cpu_addr, mem_we=cpu_req&cpu_we, mem_wdata=cpu_wdata.
- cpu_stall = cpu_req & dbg_grant, so it is high for at most one cycle per debug transaction.
- Once granted, the transaction completes and acks even if dbg_req drops in CAPT.
- wait_cnt is wide enough to hold MAX_WAIT and saturates at MAX_WAIT; it never wraps.
- Latency: dbg_req rises in cycle 0 with the CPU idle, giving PEND/grant in cycle 1, CAPT in cycle 2 and dbg_ack in cycle 3. The worst case adds MAX_WAIT cycles.
- Reset mid-operation, in any state: the next cycle is IDLE with all registers at their reset values. No ack is issued for the interrupted transaction.

Optional Feature:
DMEM_ARB_DBG_WRITE_EN
- Defined: adds the ports dbg_we (in, 1) and dbg_wdata (in, DW).
  - On a debug grant, mem_we=dbg_we and mem_wdata=dbg_wdata.
  - The handshake is unchanged: CAPT captures the old or new data as the memory returns it, and ack follows.
- Undefined: these ports do not exist and the debug port is read-only (mem_we=0 on a debug grant).

Test Plan:
- mem[0x05]=0x1234, cpu_req=0, dbg_req raised in cycle 0 with addr 0x05 -> mem_addr=0x05 in cycle 1; dbg_ack=1 and dbg_rdata=0x1234 in cycle 3 only; cpu_stall never asserted.
- cpu_req=1 continuously, MAX_WAIT=15, dbg_req raised -> debug loses 15 PEND cycles. The 16th PEND cycle is the grant with cpu_stall=1 for exactly one cycle, and dbg_ack follows 2 cycles later. Also repeat with MAX_WAIT=0 -> grant on the first PEND cycle.
- dbg_req held high through and after dbg_ack -> no second ack. Drop the request for 1 cycle and re-raise it -> a new transaction completes and acks again.
- dbg_req dropped while in PEND with cpu_req=1 -> state returns to IDLE, no ack, mem_addr never equals dbg_addr, and wait_cnt=0 on the next request.
- reset asserted in CAPT -> the following cycle shows IDLE, dbg_ack=0, dbg_rdata=0; no ack ever appears for the aborted read.
- With DMEM_ARB_DBG_WRITE_EN defined: a debug write of 0xBEEF to addr 0x0A during a CPU store to 0x02 at MAX_WAIT=0 -> mem[0x0A]=0xBEEF. The CPU store is stalled one cycle and then lands: mem[0x02] holds the CPU value.

Source files
------------

// File: rtl/dmem_port_arbiter.sv
// Shares the single-port data memory between the CPU data port and a debug readout port.
// Optional DMEM_ARB_DBG_WRITE_EN adds debug write ports (dbg_we, dbg_wdata).
module dmem_port_arbiter #(
  parameter int unsigned AW       = 8,
  parameter int unsigned DW       = 16,
  parameter int unsigned MAX_WAIT = 15
) (
  input  logic          clk,
  input  logic          reset,
  input  logic          cpu_req,
  input  logic          cpu_we,
  input  logic [AW-1:0] cpu_addr,
  input  logic [DW-1:0] cpu_wdata,
  output logic [DW-1:0] cpu_rdata,
  output logic          cpu_stall,
  input  logic          dbg_req,
  input  logic [AW-1:0] dbg_addr,
`ifdef DMEM_ARB_DBG_WRITE_EN
  input  logic          dbg_we,
  input  logic [DW-1:0] dbg_wdata,
`endif
  output logic          dbg_ack,
  output logic [DW-1:0] dbg_rdata,
  output logic [AW-1:0] mem_addr,
  output logic          mem_we,
  output logic [DW-1:0] mem_wdata,
  input  logic [DW-1:0] mem_rdata
);

  localparam int unsigned CW = (MAX_WAIT < 2) ? 1 : $clog2(MAX_WAIT + 1);
  localparam logic [CW-1:0] WAIT_MAX = CW'(MAX_WAIT);

  typedef enum logic [2:0] {
    IDLE = 3'd0,
    PEND = 3'd1,
    CAPT = 3'd2,
    ACK  = 3'd3,
    HOLD = 3'd4
  } state_t;

  state_t        state_q;
  state_t        state_d;
  logic [CW-1:0] wait_q;
  logic [CW-1:0] wait_d;
  logic          ack_q;
  logic [DW-1:0] rdata_q;
  logic          dbg_grant;

  // State register, wait counter and captured debug data
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= IDLE;
      wait_q  <= '0;
      ack_q   <= 1'b0;
      rdata_q <= '0;
    end else begin
      state_q <= state_d;
      wait_q  <= wait_d;
      ack_q   <= (state_q == CAPT);
      if (state_q == CAPT) begin
        rdata_q <= mem_rdata;
      end
    end
  end

  // Next state and grant decision
  always_comb begin
    state_d   = state_q;
    wait_d    = wait_q;
    dbg_grant = 1'b0;
    unique case (state_q)
      IDLE: begin
        if (dbg_req) begin
          state_d = PEND;
        end
      end
      PEND: begin
        if (!dbg_req) begin
          state_d = IDLE;
          wait_d  = '0;
        end else if (!cpu_req || (wait_q == WAIT_MAX)) begin
          dbg_grant = 1'b1;
          state_d   = CAPT;
          wait_d    = '0;
        end else if (wait_q != WAIT_MAX) begin
          wait_d = wait_q + CW'(1);
        end
      end
      CAPT: begin
        state_d = ACK;
      end
      ACK: begin
        state_d = dbg_req ? HOLD : IDLE;
      end
      HOLD: begin
        if (!dbg_req) begin
          state_d = IDLE;
        end
      end
      default: begin
        state_d = IDLE;
        wait_d  = '0;
      end
    endcase
  end

  // Memory port mux: the debug port owns the memory only in its grant cycle
  always_comb begin
    mem_addr  = cpu_addr;
    mem_we    = cpu_req & cpu_we;
    mem_wdata = cpu_wdata;
    if (dbg_grant) begin
      mem_addr = dbg_addr;
`ifdef DMEM_ARB_DBG_WRITE_EN
      mem_we    = dbg_we;
      mem_wdata = dbg_wdata;
`else
      mem_we    = 1'b0;
      mem_wdata = '0;
`endif
    end
  end

  assign cpu_rdata = mem_rdata;
  assign cpu_stall = cpu_req & dbg_grant;
  assign dbg_ack   = ack_q;
  assign dbg_rdata = rdata_q;

endmodule

// File: tb/tb_dmem_port_arbiter.sv
// Bench for dmem_port_arbiter: a MAX_WAIT=15 and a MAX_WAIT=0 instance share stimulus,
// each with its own synchronous memory model; debug read data is scoreboarded.
module tb_dmem_port_arbiter;

  logic        clk;
  logic        reset;
  logic        mem_load;
  logic        cpu_req, cpu_we, dbg_req;
  logic [7:0]  cpu_addr, dbg_addr;
  logic [15:0] cpu_wdata;
`ifdef DMEM_ARB_DBG_WRITE_EN
  logic        dbg_we;
  logic [15:0] dbg_wdata;
  localparam logic        EXP_DWE  = 1'b1;
  localparam logic [15:0] EXP_MEMA = 16'hBEEF;
`else
  localparam logic        EXP_DWE  = 1'b0;
  localparam logic [15:0] EXP_MEMA = 16'hAFAF;
`endif

  logic [15:0] cpu_rdata_a, dbg_rdata_a, mem_wdata_a, mem_rdata_a;
  logic [7:0]  mem_addr_a;
  logic        cpu_stall_a, dbg_ack_a, mem_we_a;
  logic [15:0] cpu_rdata_b, dbg_rdata_b, mem_wdata_b, mem_rdata_b;
  logic [7:0]  mem_addr_b;
  logic        cpu_stall_b, dbg_ack_b, mem_we_b;

  logic [15:0] mem_a [256];
  logic [15:0] mem_b [256];
  logic [15:0] sb [$];

  int n_vec = 0;
  int n_mis = 0;

  dmem_port_arbiter #(.AW(8), .DW(16), .MAX_WAIT(15)) u_dut (
    .clk(clk), .reset(reset),
    .cpu_req(cpu_req), .cpu_we(cpu_we), .cpu_addr(cpu_addr), .cpu_wdata(cpu_wdata),
    .cpu_rdata(cpu_rdata_a), .cpu_stall(cpu_stall_a),
    .dbg_req(dbg_req), .dbg_addr(dbg_addr),
`ifdef DMEM_ARB_DBG_WRITE_EN
    .dbg_we(dbg_we), .dbg_wdata(dbg_wdata),
`endif
    .dbg_ack(dbg_ack_a), .dbg_rdata(dbg_rdata_a),
    .mem_addr(mem_addr_a), .mem_we(mem_we_a), .mem_wdata(mem_wdata_a), .mem_rdata(mem_rdata_a)
  );

  dmem_port_arbiter #(.AW(8), .DW(16), .MAX_WAIT(0)) u_dut0 (
    .clk(clk), .reset(reset),
    .cpu_req(cpu_req), .cpu_we(cpu_we), .cpu_addr(cpu_addr), .cpu_wdata(cpu_wdata),
    .cpu_rdata(cpu_rdata_b), .cpu_stall(cpu_stall_b),
    .dbg_req(dbg_req), .dbg_addr(dbg_addr),
`ifdef DMEM_ARB_DBG_WRITE_EN
    .dbg_we(dbg_we), .dbg_wdata(dbg_wdata),
`endif
    .dbg_ack(dbg_ack_b), .dbg_rdata(dbg_rdata_b),
    .mem_addr(mem_addr_b), .mem_we(mem_we_b), .mem_wdata(mem_wdata_b), .mem_rdata(mem_rdata_b)
  );

  function automatic logic [15:0] fill(input int unsigned a);
    fill = (a == 5) ? 16'h1234 : (16'(a * 257) ^ 16'hA5A5);
  endfunction

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Synchronous-read memory models, read-before-write
  always @(posedge clk) begin
    if (mem_load) begin
      for (int i = 0; i < 256; i++) begin
        mem_a[i] <= fill(i);
        mem_b[i] <= fill(i);
      end
    end else begin
      if (mem_we_a) mem_a[mem_addr_a] <= mem_wdata_a;
      if (mem_we_b) mem_b[mem_addr_b] <= mem_wdata_b;
    end
    mem_rdata_a <= mem_a[mem_addr_a];
    mem_rdata_b <= mem_b[mem_addr_b];
  end

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_mis++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  // Scoreboard: every ack of the MAX_WAIT=15 instance must match the oldest expected read
  always @(negedge clk) begin
    if (dbg_ack_a) begin
      if (sb.size() == 0) check("unexpected_ack", 64'd1, 64'd0);
      else check("ack_rdata", 64'(dbg_rdata_a), 64'(sb.pop_front()));
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  typedef struct {
    logic        cpu_req;
    logic        cpu_we;
    logic [7:0]  cpu_addr;
    logic [15:0] cpu_wdata;
    logic        dbg_req;
    logic [7:0]  dbg_addr;
    logic [7:0]  e_addr;
    logic        e_we;
    logic [15:0] e_wdata;
    logic        e_stall;
    logic        e_ack;
    logic        chk_rd;
    logic [15:0] e_rd;
    logic        push;
    logic [15:0] push_data;
  } vec_t;

  vec_t vt [14];

  initial begin
    int hits, acks, stalls, first_stall, ack_cyc;
    int stalls0, first_stall0, acks0, ack_cyc0;

    vt[0]  = '{1'b0, 1'b0, 8'h20, 16'h0000, 1'b1, 8'h05, 8'h20, 1'b0, 16'h0000, 1'b0, 1'b0, 1'b0, 16'h0000, 1'b1, 16'h1234};
    vt[1]  = '{1'b0, 1'b0, 8'h20, 16'h0000, 1'b1, 8'h05, 8'h05, 1'b0, 16'h0000, 1'b0, 1'b0, 1'b0, 16'h0000, 1'b0, 16'h0000};
    vt[2]  = '{1'b1, 1'b1, 8'h21, 16'h5555, 1'b1, 8'h05, 8'h21, 1'b1, 16'h5555, 1'b0, 1'b0, 1'b0, 16'h0000, 1'b0, 16'h0000};
    vt[3]  = '{1'b1, 1'b0, 8'h21, 16'h5555, 1'b1, 8'h05, 8'h21, 1'b0, 16'h5555, 1'b0, 1'b1, 1'b0, 16'h0000, 1'b0, 16'h0000};
    vt[4]  = '{1'b0, 1'b0, 8'h20, 16'h0000, 1'b1, 8'h05, 8'h20, 1'b0, 16'h0000, 1'b0, 1'b0, 1'b1, 16'h5555, 1'b0, 16'h0000};
    vt[5]  = '{1'b1, 1'b0, 8'h22, 16'h0000, 1'b1, 8'h05, 8'h22, 1'b0, 16'h0000, 1'b0, 1'b0, 1'b0, 16'h0000, 1'b0, 16'h0000};
    vt[6]  = '{1'b0, 1'b0, 8'h20, 16'h0000, 1'b0, 8'h05, 8'h20, 1'b0, 16'h0000, 1'b0, 1'b0, 1'b1, 16'h8787, 1'b0, 16'h0000};
    vt[7]  = '{1'b1, 1'b0, 8'h20, 16'h0000, 1'b1, 8'h06, 8'h20, 1'b0, 16'h0000, 1'b0, 1'b0, 1'b0, 16'h0000, 1'b1, 16'hA3A3};
    vt[8]  = '{1'b1, 1'b1, 8'h23, 16'h9999, 1'b1, 8'h06, 8'h23, 1'b1, 16'h9999, 1'b0, 1'b0, 1'b0, 16'h0000, 1'b0, 16'h0000};
    vt[9]  = '{1'b0, 1'b0, 8'h20, 16'h0000, 1'b1, 8'h06, 8'h06, 1'b0, 16'h0000, 1'b0, 1'b0, 1'b0, 16'h0000, 1'b0, 16'h0000};
    vt[10] = '{1'b0, 1'b0, 8'h20, 16'h0000, 1'b0, 8'h06, 8'h20, 1'b0, 16'h0000, 1'b0, 1'b0, 1'b0, 16'h0000, 1'b0, 16'h0000};
    vt[11] = '{1'b1, 1'b0, 8'h23, 16'h0000, 1'b0, 8'h06, 8'h23, 1'b0, 16'h0000, 1'b0, 1'b1, 1'b0, 16'h0000, 1'b0, 16'h0000};
    vt[12] = '{1'b0, 1'b0, 8'h20, 16'h0000, 1'b0, 8'h06, 8'h20, 1'b0, 16'h0000, 1'b0, 1'b0, 1'b1, 16'h9999, 1'b0, 16'h0000};
    vt[13] = '{1'b0, 1'b0, 8'h20, 16'h0000, 1'b0, 8'h06, 8'h20, 1'b0, 16'h0000, 1'b0, 1'b0, 1'b1, 16'h8585, 1'b0, 16'h0000};

    reset = 1'b1; mem_load = 1'b1;
    cpu_req = 1'b0; cpu_we = 1'b0; cpu_addr = 8'h20; cpu_wdata = 16'h0000;
    dbg_req = 1'b0; dbg_addr = 8'h00;
`ifdef DMEM_ARB_DBG_WRITE_EN
    dbg_we = 1'b0; dbg_wdata = 16'h0000;
`endif
    repeat (3) tick();
    @(negedge clk);
    check("reset_a", 64'({dbg_ack_a, dbg_rdata_a, cpu_stall_a}), 64'd0);
    check("reset_b", 64'({dbg_ack_b, dbg_rdata_b, cpu_stall_b}), 64'd0);
    tick();
    reset = 1'b0; mem_load = 1'b0;

    // Table: basic read, hold-without-reack, re-request, drop in CAPT
    for (int i = 0; i < 14; i++) begin
      cpu_req = vt[i].cpu_req; cpu_we = vt[i].cpu_we;
      cpu_addr = vt[i].cpu_addr; cpu_wdata = vt[i].cpu_wdata;
      dbg_req = vt[i].dbg_req; dbg_addr = vt[i].dbg_addr;
      if (vt[i].push) sb.push_back(vt[i].push_data);
      @(negedge clk);
      check($sformatf("vec%0d", i),
            64'({mem_addr_a, mem_we_a, mem_wdata_a, cpu_stall_a, dbg_ack_a}),
            64'({vt[i].e_addr, vt[i].e_we, vt[i].e_wdata, vt[i].e_stall, vt[i].e_ack}));
      if (vt[i].chk_rd) check($sformatf("vec%0d_cpu_rdata", i), 64'(cpu_rdata_a), 64'(vt[i].e_rd));
      tick();
    end

    // Abort in PEND while the CPU is busy
    cpu_req = 1'b1; cpu_we = 1'b0; cpu_addr = 8'h30; dbg_addr = 8'h07;
    hits = 0; acks = 0; stalls = 0;
    for (int c = 0; c < 11; c++) begin
      dbg_req = (c <= 4);
      @(negedge clk);
      if (mem_addr_a == 8'h07) hits++;
      if (dbg_ack_a) acks++;
      if (cpu_stall_a) stalls++;
      tick();
    end
    check("abort_addr_hits", 64'(hits), 64'd0);
    check("abort_acks", 64'(acks), 64'd0);
    check("abort_stalls", 64'(stalls), 64'd0);

    // Bounded wait with the CPU requesting every cycle; request held past the ack
    cpu_req = 1'b1; cpu_we = 1'b0; cpu_addr = 8'h30; dbg_addr = 8'h05; dbg_req = 1'b1;
    sb.push_back(16'h1234);
    stalls = 0; first_stall = -1; acks = 0; ack_cyc = -1; hits = 0;
    stalls0 = 0; first_stall0 = -1; acks0 = 0; ack_cyc0 = -1;
    for (int c = 0; c < 40; c++) begin
      @(negedge clk);
      if (cpu_stall_a) begin
        stalls++; first_stall = c;
        if (mem_addr_a == 8'h05 && !mem_we_a) hits++;
      end
      if (dbg_ack_a) begin acks++; ack_cyc = c; end
      if (cpu_stall_b) begin stalls0++; first_stall0 = c; end
      if (dbg_ack_b) begin acks0++; ack_cyc0 = c; end
      tick();
    end
    dbg_req = 1'b0;
    check("wait15_stall_cycle", 64'(first_stall), 64'd16);
    check("wait15_stall_count", 64'(stalls), 64'd1);
    check("wait15_grant_mux", 64'(hits), 64'd1);
    check("wait15_ack_cycle", 64'(ack_cyc), 64'd18);
    check("wait15_ack_count", 64'(acks), 64'd1);
    check("wait0_stall_cycle", 64'(first_stall0), 64'd1);
    check("wait0_stall_count", 64'(stalls0), 64'd1);
    check("wait0_ack_cycle", 64'(ack_cyc0), 64'd3);
    check("wait0_ack_count", 64'(acks0), 64'd1);
    repeat (2) tick();

    // Debug access colliding with a CPU store (checked on the MAX_WAIT=0 instance)
    cpu_req = 1'b0; cpu_we = 1'b0; cpu_addr = 8'h30; cpu_wdata = 16'h0000;
    dbg_req = 1'b1; dbg_addr = 8'h0A;
`ifdef DMEM_ARB_DBG_WRITE_EN
    dbg_we = 1'b1; dbg_wdata = 16'hBEEF;
`endif
    sb.push_back(16'hAFAF);
    tick();
    cpu_req = 1'b1; cpu_we = 1'b1; cpu_addr = 8'h02; cpu_wdata = 16'h7777;
    @(negedge clk);
    check("wr_grant_b", 64'({cpu_stall_b, mem_addr_b, mem_we_b}), 64'({1'b1, 8'h0A, EXP_DWE}));
    tick();
    @(negedge clk);
    check("wr_cpu_lands_b", 64'({cpu_stall_b, mem_addr_b, mem_we_b}), 64'({1'b0, 8'h02, 1'b1}));
    tick();
    cpu_req = 1'b0; cpu_we = 1'b0;
    @(negedge clk);
    check("wr_ack_b", 64'(dbg_ack_b), 64'd1);
    tick();
    dbg_req = 1'b0;
`ifdef DMEM_ARB_DBG_WRITE_EN
    dbg_we = 1'b0;
`endif
    repeat (4) tick();
    check("wr_mem_cpu", 64'(mem_b[8'h02]), 64'h7777);
    check("wr_mem_dbg", 64'(mem_b[8'h0A]), 64'(EXP_MEMA));

    // Reset while in CAPT: no ack, registers cleared
    cpu_req = 1'b0; cpu_addr = 8'h30; dbg_addr = 8'h05; dbg_req = 1'b1;
    tick();
    @(negedge clk);
    check("rst_pend_grant", 64'(mem_addr_a), 64'h05);
    tick();
    reset = 1'b1; dbg_req = 1'b0;
    tick();
    reset = 1'b0;
    @(negedge clk);
    check("rst_capt_a", 64'({dbg_ack_a, dbg_rdata_a, mem_addr_a}), 64'({1'b0, 16'h0000, 8'h30}));
    check("rst_capt_b", 64'({dbg_ack_b, dbg_rdata_b, mem_addr_b}), 64'({1'b0, 16'h0000, 8'h30}));
    acks = 0;
    for (int c = 0; c < 6; c++) begin
      tick();
      @(negedge clk);
      if (dbg_ack_a || dbg_ack_b) acks++;
    end
    check("rst_no_ack", 64'(acks), 64'd0);
    check("sb_drained", 64'(sb.size()), 64'd0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_mis);
    $finish;
  end

endmodule
